// File: rtl/wb_pkg.sv
// Shared types and constants for the register-file writeback stage.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 32;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [ADDR_W-1:0] rd;
        logic [DATA_W-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fifo.sv
// Small FIFO buffering long-latency writeback requests; pushes into a full FIFO and pops from
// an empty FIFO are ignored.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    push,
    input  wb_req_t din,
    input  logic    pop,
    output wb_req_t dout,
    output logic    full,
    output logic    empty
);

    localparam int PW = $clog2(DEPTH);

    wb_req_t         mem_r [DEPTH];
    logic [PW-1:0]   wr_ptr_r;
    logic [PW-1:0]   rd_ptr_r;
    logic [PW:0]     count_r;
    logic            push_ok_s;
    logic            pop_ok_s;
    logic            full_s;
    logic            empty_s;

    // Occupancy flags and qualified handshakes.
    always_comb begin
        full_s    = (count_r == (PW+1)'(DEPTH));
        empty_s   = (count_r == (PW+1)'(0));
        push_ok_s = push & ~full_s;
        pop_ok_s  = pop & ~empty_s;
    end

    // Pointers and occupancy counter; a simultaneous push and pop leaves the count unchanged.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_r <= PW'(0);
            rd_ptr_r <= PW'(0);
            count_r  <= (PW+1)'(0);
        end else begin
            if (push_ok_s) wr_ptr_r <= wr_ptr_r + PW'(1);
            if (pop_ok_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + (PW+1)'(1);
                2'b01:   count_r <= count_r - (PW+1)'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Storage array; contents need no reset because the pointers define validity.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_r[wr_ptr_r] <= din;
    end

    assign dout  = mem_r[rd_ptr_r];
    assign full  = full_s;
    assign empty = empty_s;

endmodule

// File: rtl/reg_writeback.sv
// Writeback stage merging ALU and long-latency results into the register-file write port.
// Build option WB_BYPASS_EN forwards the in-flight write onto the execute operands.
module reg_writeback
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid,
    input  logic [ADDR_W-1:0]   alu_rd,
    input  logic [DATA_W-1:0]   alu_data,
    input  logic                lu_valid,
    output logic                lu_ready,
    input  logic [ADDR_W-1:0]   lu_rd,
    input  logic [DATA_W-1:0]   lu_data,
    input  logic                iss_set,
    input  logic [ADDR_W-1:0]   iss_rd,
    output logic [NUM_REGS-1:0] pend,
    output logic                write,
    output logic [ADDR_W-1:0]   rw,
    output logic [DATA_W-1:0]   busw,
    input  logic [ADDR_W-1:0]   ra,
    input  logic [ADDR_W-1:0]   rb,
    input  logic [DATA_W-1:0]   busa_in,
    input  logic [DATA_W-1:0]   busb_in,
    output logic [DATA_W-1:0]   opa,
    output logic [DATA_W-1:0]   opb
);

    wb_req_t             head_s;
    wb_req_t             sel_s;
    logic                sel_valid_s;
    logic                pop_s;
    logic                push_s;
    logic                full_s;
    logic                empty_s;
    logic                lu_ready_s;
    logic [NUM_REGS-1:0] pend_next_s;
    logic [NUM_REGS-1:0] pend_r;
    logic                write_r;
    logic [ADDR_W-1:0]   rw_r;
    logic [DATA_W-1:0]   busw_r;

    // Acceptance depends only on current occupancy, never on a same-cycle pop.
    always_comb begin
        if (reset) begin
            lu_ready_s = 1'b0;
        end else begin
            lu_ready_s = ~full_s;
        end
        push_s = lu_valid & lu_ready_s;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push_s),
        .din   ({lu_rd, lu_data}),
        .pop   (pop_s),
        .dout  (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    // Fixed-priority source select: the ALU path never stalls, the FIFO drains when it is idle.
    always_comb begin
        sel_s       = '{rd: alu_rd, data: alu_data};
        sel_valid_s = 1'b0;
        pop_s       = 1'b0;
        if (alu_valid) begin
            sel_valid_s = 1'b1;
        end else if (!empty_s) begin
            sel_s       = head_s;
            sel_valid_s = 1'b1;
            pop_s       = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
        end
    end

    // Register-file write port; an r0 request is consumed without a write pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            write_r <= 1'b0;
            rw_r    <= REG_ZERO;
            busw_r  <= 32'd0;
        end else if (sel_valid_s) begin
            write_r <= (sel_s.rd != REG_ZERO);
            rw_r    <= sel_s.rd;
            busw_r  <= sel_s.data;
        end else begin
            write_r <= 1'b0;
        end
    end

    // Scoreboard next state: the retiring write clears its bit, a new issue on the same bit wins.
    always_comb begin
        pend_next_s = pend_r;
        if (sel_valid_s && (sel_s.rd != REG_ZERO)) begin
            pend_next_s[sel_s.rd] = 1'b0;
        end else begin
            pend_next_s = pend_r;
        end
        if (iss_set && (iss_rd != REG_ZERO)) begin
            pend_next_s[iss_rd] = 1'b1;
        end else begin
            pend_next_s = pend_next_s;
        end
        pend_next_s[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_r <= 32'd0;
        end else begin
            pend_r <= pend_next_s;
        end
    end

`ifdef WB_BYPASS_EN
    // Forward the write being performed this cycle, since the register file still reads old data.
    always_comb begin
        if (write_r && (rw_r == ra) && (ra != REG_ZERO)) begin
            opa = busw_r;
        end else begin
            opa = busa_in;
        end
        if (write_r && (rw_r == rb) && (rb != REG_ZERO)) begin
            opb = busw_r;
        end else begin
            opb = busb_in;
        end
    end
`else
    logic unused_bypass_s;
    assign unused_bypass_s = ^{ra, rb};
    assign opa = busa_in;
    assign opb = busb_in;
`endif

    assign lu_ready = lu_ready_s;
    assign pend     = pend_r;
    assign write    = write_r;
    assign rw       = rw_r;
    assign busw     = busw_r;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed, table-driven bench for reg_writeback; expected bypass values follow WB_BYPASS_EN.
module tb_reg_writeback;
    import wb_pkg::*;

    logic                clk = 1'b0;
    logic                reset;
    logic                alu_valid, lu_valid, lu_ready, iss_set, write;
    logic [ADDR_W-1:0]   alu_rd, lu_rd, iss_rd, rw, ra, rb;
    logic [DATA_W-1:0]   alu_data, lu_data, busw, busa_in, busb_in, opa, opb;
    logic [NUM_REGS-1:0] pend;

    int checks = 0;
    int errors = 0;

    reg_writeback #(.DEPTH(4)) dut (
        .clk(clk), .reset(reset),
        .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
        .lu_valid(lu_valid), .lu_ready(lu_ready), .lu_rd(lu_rd), .lu_data(lu_data),
        .iss_set(iss_set), .iss_rd(iss_rd), .pend(pend),
        .write(write), .rw(rw), .busw(busw),
        .ra(ra), .rb(rb), .busa_in(busa_in), .busb_in(busb_in),
        .opa(opa), .opb(opb)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        av;  logic [4:0] ard; logic [31:0] adata;
        logic        lv;  logic [4:0] lrd; logic [31:0] ldata;
        logic        is;  logic [4:0] ird;
        logic        ewr; logic [4:0] erw; logic [31:0] ebusw;
        logic [31:0] epend; logic erdy;
    } vec_t;

    vec_t vecs [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adata,
                         input logic lv, input logic [4:0] lrd, input logic [31:0] ldata,
                         input logic is, input logic [4:0] ird);
        alu_valid = av; alu_rd = ard; alu_data = adata;
        lu_valid = lv;  lu_rd = lrd;  lu_data = ldata;
        iss_set = is;   iss_rd = ird;
    endtask

    task automatic chk_wb(input string name, input logic ewr, input logic [4:0] erw,
                          input logic [31:0] ebusw);
        chk({name, ".write"}, {31'd0, write}, {31'd0, ewr});
        chk({name, ".rw"}, {27'd0, rw}, {27'd0, erw});
        chk({name, ".busw"}, busw, ebusw);
    endtask

    initial begin
        logic [31:0] exp_byp;

        vecs[0]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,
                     1'b0, 5'd0,  32'h0,        32'h0,         1'b1};
        vecs[1]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 32'h0,  1'b0, 5'd0,
                     1'b1, 5'd5,  32'hDEADBEEF, 32'h0,         1'b1};
        vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd9,
                     1'b0, 5'd5,  32'hDEADBEEF, 32'h0000_0200, 1'b1};
        vecs[3]  = '{1'b1, 5'd3,  32'h33,       1'b1, 5'd7, 32'h77, 1'b0, 5'd0,
                     1'b1, 5'd3,  32'h33,       32'h0000_0200, 1'b1};
        vecs[4]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,
                     1'b1, 5'd7,  32'h77,       32'h0000_0200, 1'b1};
        vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 32'hAA, 1'b0, 5'd0,
                     1'b0, 5'd7,  32'h77,       32'h0000_0200, 1'b1};
        vecs[6]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b0, 5'd0,
                     1'b0, 5'd0,  32'hAA,       32'h0000_0200, 1'b1};
        vecs[7]  = '{1'b1, 5'd9,  32'h99,       1'b0, 5'd0, 32'h0,  1'b1, 5'd9,
                     1'b1, 5'd9,  32'h99,       32'h0000_0200, 1'b1};
        vecs[8]  = '{1'b1, 5'd9,  32'h98,       1'b0, 5'd0, 32'h0,  1'b0, 5'd0,
                     1'b1, 5'd9,  32'h98,       32'h0,         1'b1};
        vecs[9]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0, 32'h0,  1'b1, 5'd0,
                     1'b0, 5'd9,  32'h98,       32'h0,         1'b1};
        vecs[10] = '{1'b1, 5'd12, 32'h12,       1'b0, 5'd0, 32'h0,  1'b1, 5'd12,
                     1'b1, 5'd12, 32'h12,       32'h0000_1000, 1'b1};
        vecs[11] = '{1'b1, 5'd12, 32'h13,       1'b0, 5'd0, 32'h0,  1'b1, 5'd20,
                     1'b1, 5'd12, 32'h13,       32'h0010_0000, 1'b1};

        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        ra = 5'd0; rb = 5'd0; busa_in = 32'h11; busb_in = 32'h22;
        tick();
        tick();
        chk_wb("reset", 1'b0, 5'd0, 32'h0);
        chk("reset.pend", pend, 32'h0);
        chk("reset.lu_ready", {31'd0, lu_ready}, 32'd0);
        reset = 1'b0;

        // Table of single-cycle vectors.
        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].av, vecs[i].ard, vecs[i].adata, vecs[i].lv, vecs[i].lrd,
                  vecs[i].ldata, vecs[i].is, vecs[i].ird);
            tick();
            chk_wb($sformatf("vec%0d", i), vecs[i].ewr, vecs[i].erw, vecs[i].ebusw);
            chk($sformatf("vec%0d.pend", i), pend, vecs[i].epend);
            chk($sformatf("vec%0d.lu_ready", i), {31'd0, lu_ready}, {31'd0, vecs[i].erdy});
        end

        // Backpressure: fill the FIFO under continuous ALU traffic.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 5'd2, 32'hA0 + i, 1'b1, 5'(21 + i), 32'h100 + i, 1'b0, 5'd0);
            tick();
            chk_wb($sformatf("fill%0d", i), 1'b1, 5'd2, 32'hA0 + i);
            chk($sformatf("fill%0d.lu_ready", i), {31'd0, lu_ready}, (i < 3) ? 32'd1 : 32'd0);
        end
        drive(1'b1, 5'd2, 32'hA4, 1'b1, 5'd25, 32'h125, 1'b0, 5'd0);
        tick();
        chk("full_hold.lu_ready", {31'd0, lu_ready}, 32'd0);
        // Pop while full: the offered r25 must not be accepted.
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd25, 32'h125, 1'b0, 5'd0);
        tick();
        chk_wb("drain0", 1'b1, 5'd21, 32'h100);
        chk("drain0.lu_ready", {31'd0, lu_ready}, 32'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        for (int i = 1; i < 4; i++) begin
            tick();
            chk_wb($sformatf("drain%0d", i), 1'b1, 5'(21 + i), 32'h100 + i);
        end
        tick();
        chk_wb("drain_done", 1'b0, 5'd24, 32'h103);
        chk("drain_done.pend", pend, 32'h0010_0000);

        // Bypass of the in-flight write.
        drive(1'b1, 5'd4, 32'h55, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        ra = 5'd4; rb = 5'd4; busa_in = 32'h11; busb_in = 32'h22;
        tick();
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
`ifdef WB_BYPASS_EN
        exp_byp = 32'h55;
`else
        exp_byp = 32'h11;
`endif
        chk_wb("bypass", 1'b1, 5'd4, 32'h55);
        chk("bypass.opa", opa, exp_byp);
        rb = 5'd0;
        #1;
        chk("bypass.opb_r0", opb, 32'h22);
        ra = 5'd0;
        #1;
        chk("bypass.opa_r0", opa, 32'h11);
        ra = 5'd4;
        tick();
        chk("bypass.opa_idle", opa, 32'h11);

        // Reset mid-stream with three buffered entries and a pending bit.
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 5'd2, 32'hB0 + i, 1'b1, 5'(26 + i), 32'h200 + i, (i == 0), 5'd30);
            tick();
        end
        chk("pre_reset.pend", pend, 32'h4010_0000);
        chk("pre_reset.write", {31'd0, write}, 32'd1);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0);
        reset = 1'b1;
        #1;
        chk_wb("midreset", 1'b0, 5'd0, 32'h0);
        chk("midreset.pend", pend, 32'h0);
        chk("midreset.lu_ready", {31'd0, lu_ready}, 32'd0);
        tick();
        reset = 1'b0;
        #1;
        chk("post_reset.lu_ready", {31'd0, lu_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("post_reset%0d.write", i), {31'd0, write}, 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
